// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer feeding a one-entry registered output buffer.
// Define ARB_MUX_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel,
  output logic               dbg_state_o,
  output logic [SELW-1:0]    dbg_ptr_o
);

  // Handshake: a word moves on any edge where valid and ready are both high
  // at the sampling edge; valid must not depend on ready, ready may depend on valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  data_q;
  logic [SELW-1:0]   sel_q;
  logic              load_ok;
  logic              xfer;
  logic [N-1:0]      grant;
  logic [SELW-1:0]   gnt_idx;
  logic              found;

`ifdef ARB_MUX_RR_EN
  logic [SELW-1:0]   ptr_q;
  logic [SELW-1:0]   ptr_d;
  int                idx;

  // Search starts at the pointer and wraps at N, not at 2^SELW.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = SELW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (gnt_idx == SELW'(N - 1)) ptr_d = '0;
      else                         ptr_d = gnt_idx + 1'b1;
    end
  end

  assign dbg_ptr_o = ptr_q;
`else
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && in_valid[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        gnt_idx  = SELW'(k);
      end
    end
  end

  assign dbg_ptr_o = '0;
`endif

  assign load_ok  = (state_q == EMPTY) || out_ready;
  assign in_ready = grant & {N{load_ok & ~reset}};
  assign xfer     = |in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
`ifdef ARB_MUX_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      if (xfer) begin
        state_q <= FULL;
        data_q  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        sel_q   <= gnt_idx;
      end else if (state_q == FULL && out_ready) begin
        // Drain only: data and index keep their last values.
        state_q <= EMPTY;
      end
`ifdef ARB_MUX_RR_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign out_valid   = (state_q == FULL);
  assign out_data    = data_q;
  assign out_sel     = sel_q;
  assign dbg_state_o = state_q;

endmodule
